trng_stream: RTL

TRNG_STREAM -- requirements
Module: trng_stream

---
 rtl/trng_pkg.sv | 13 +
 rtl/trng_health.sv | 49 ++++
 rtl/trng_stream.sv | 133 +++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG stream generator.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FAULT  = 2'd3
    } trng_state_e;

    localparam logic [7:0] TRNG_DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/trng_health.sv
// Repetition-count health test: flags a run of RCT_LIMIT identical accepted bits.
module trng_health #(
    parameter int unsigned RCT_LIMIT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_i,
    input  logic valid_i,
    input  logic clear_i,
    output logic fail_o
);

    localparam int unsigned CW = $clog2(RCT_LIMIT + 1);

    logic [CW-1:0] run_q, run_d, run_next;
    logic          last_q, last_d;

    // Run length including the bit offered this cycle; saturates at the limit.
    always_comb begin
        if (run_q != '0 && bit_i == last_q) begin
            run_next = (run_q == CW'(RCT_LIMIT)) ? run_q : run_q + CW'(1);
        end else begin
            run_next = CW'(1);
        end
        // fail is independent of clear so the FSM can use it without a loop
        fail_o = valid_i && (run_next == CW'(RCT_LIMIT));
        run_d  = run_q;
        last_d = last_q;
        if (clear_i) begin
            run_d  = '0;
            last_d = 1'b0;
        end else if (valid_i) begin
            run_d  = run_next;
            last_d = bit_i;
        end
    end

    // Run counter and previous-bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/trng_stream.sv
// Whitened random word stream: collects entropy bits, XORs with an LFSR,
// gates output through warmup and a repetition-count health test.
module trng_stream
    import trng_pkg::*;
#(
    parameter int unsigned            WIDTH        = 8,
    parameter logic [WIDTH-1:0]       LFSR_TAPS    = WIDTH'(TRNG_DEFAULT_TAPS),
    parameter int unsigned            RCT_LIMIT    = 32,
    parameter int unsigned            WARMUP_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             entropy_bit,
    input  logic             entropy_valid,
    input  logic             clear_fault,
    input  logic             rand_ready,
    output logic [WIDTH-1:0] rand_out,
    output logic             rand_valid,
    output logic             fault
);

    localparam int unsigned BCW = $clog2(WIDTH);
    localparam int unsigned WCW = (WARMUP_WORDS > 1) ? $clog2(WARMUP_WORDS) : 1;
    localparam trng_state_e START_ST = (WARMUP_WORDS == 0) ? RUN : WARMUP;

    trng_state_e      state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] col_q, col_d, col_shift;
    logic [WIDTH-1:0] out_q, out_d, word;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             valid_q, valid_d;
    logic             active, accept, word_done, rct_fail, going_quiet;

    assign active    = (state_q == WARMUP) || (state_q == RUN);
    assign accept    = active && entropy_valid;
    assign col_shift = {col_q[WIDTH-2:0], entropy_bit};
    assign word_done = accept && (bcnt_q == BCW'(WIDTH - 1));
    assign word      = col_shift ^ lfsr_q;

    trng_health #(
        .RCT_LIMIT (RCT_LIMIT)
    ) u_health (
        .clk     (clk),
        .reset   (reset),
        .bit_i   (entropy_bit),
        .valid_i (accept),
        .clear_i (!active || going_quiet),
        .fail_o  (rct_fail)
    );

    // Next-state logic; health failure outranks enable dropping.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (enable) state_d = START_ST;
            WARMUP: begin
                if (rct_fail)     state_d = FAULT;
                else if (!enable) state_d = IDLE;
                else if (word_done && wcnt_q == WCW'(WARMUP_WORDS - 1)) state_d = RUN;
            end
            RUN: begin
                if (rct_fail)     state_d = FAULT;
                else if (!enable) state_d = IDLE;
            end
            FAULT:  if (clear_fault) state_d = enable ? START_ST : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign going_quiet = (state_d == IDLE) || (state_d == FAULT);

    // Collector, counters and output handshake.
    always_comb begin
        col_d   = col_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (going_quiet) begin
            col_d   = '0;
            bcnt_d  = '0;
            wcnt_d  = '0;
            valid_d = 1'b0;
        end else begin
            if (accept) begin
                col_d  = col_shift;
                bcnt_d = word_done ? '0 : bcnt_q + BCW'(1);
            end
            if (state_q == WARMUP && word_done) wcnt_d = wcnt_q + WCW'(1);
            if (state_q == RUN && word_done && (!valid_q || rand_ready)) begin
                out_d   = word;
                valid_d = 1'b1;
            end else if (valid_q && rand_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    // Galois LFSR step with all-zero lock-up escape.
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_q == '0)  lfsr_d = '1;
        else if (enable)   lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= '1;
            col_q   <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            col_q   <= col_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign rand_out   = out_q;
    assign rand_valid = valid_q;
    assign fault      = (state_q == FAULT);

endmodule
